// File: rtl/ex_muldiv_pkg.sv
`default_nettype none
// ============================================================================
// Module  : ex_muldiv_pkg
// Purpose : Op codes and FSM encodings shared by the EX-stage mul/div unit.
// Revision: 1.0
// ============================================================================
package ex_muldiv_pkg;

    typedef enum logic [1:0] {
        MD_MULT  = 2'd0,
        MD_MULTU = 2'd1,
        MD_DIV   = 2'd2,
        MD_DIVU  = 2'd3
    } md_op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2,
        S_DONE = 2'd3
    } md_state_e;

    function automatic logic md_is_div(input md_op_e op);
        return (op == MD_DIV) || (op == MD_DIVU);
    endfunction

    function automatic logic md_is_signed(input md_op_e op);
        return (op == MD_MULT) || (op == MD_DIV);
    endfunction

endpackage
`default_nettype wire

// File: rtl/ex_muldiv_div.sv
`default_nettype none
// ============================================================================
// Module  : ex_muldiv_div
// Purpose : Iterative restoring radix-2 divider, one quotient bit per cycle.
// Revision: 1.0
// ============================================================================
module ex_muldiv_div #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              abort_i,
    input  logic              start_i,
    input  logic              signed_i,
    input  logic [DATA_W-1:0] opa_i,
    input  logic [DATA_W-1:0] opb_i,
    output logic              ready_o,
    output logic [DATA_W-1:0] quotient_o,
    output logic [DATA_W-1:0] remainder_o
);

    localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    logic              busy_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [DATA_W-1:0] rem_q;
    logic [DATA_W-1:0] quo_q;
    logic [DATA_W-1:0] dvs_q;
    logic              neg_quo_q;
    logic              neg_rem_q;

    logic              a_neg;
    logic              b_neg;
    logic [DATA_W-1:0] a_mag;
    logic [DATA_W-1:0] b_mag;
    logic [DATA_W:0]   trial;
    logic [DATA_W:0]   diff;
    logic              ge;
    logic [DATA_W-1:0] rem_d;
    logic [DATA_W-1:0] quo_d;

    assign a_neg = signed_i & opa_i[DATA_W-1];
    assign b_neg = signed_i & opb_i[DATA_W-1];
    assign a_mag = a_neg ? (~opa_i + 1'b1) : opa_i;
    assign b_mag = b_neg ? (~opb_i + 1'b1) : opb_i;

    // Shift the next dividend bit into the partial remainder and try to subtract.
    assign trial = {rem_q, quo_q[DATA_W-1]};
    assign diff  = trial - {1'b0, dvs_q};
    assign ge    = ~diff[DATA_W];
    assign rem_d = ge ? diff[DATA_W-1:0] : trial[DATA_W-1:0];
    assign quo_d = {quo_q[DATA_W-2:0], ge};

    // Results are taken straight from the final iteration so the caller can
    // register them on the same edge that ends the divide.
    assign ready_o     = busy_q & (cnt_q == CNT_W'(DATA_W - 1));
    assign quotient_o  = neg_quo_q ? (~quo_d + 1'b1) : quo_d;
    assign remainder_o = neg_rem_q ? (~rem_d + 1'b1) : rem_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_q    <= 1'b0;
            cnt_q     <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            dvs_q     <= '0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
        end else if (abort_i) begin
            busy_q <= 1'b0;
        end else if (start_i) begin
            busy_q    <= 1'b1;
            cnt_q     <= '0;
            rem_q     <= '0;
            quo_q     <= a_mag;
            dvs_q     <= b_mag;
            neg_quo_q <= a_neg ^ b_neg;
            neg_rem_q <= a_neg;
        end else if (busy_q) begin
            rem_q <= rem_d;
            quo_q <= quo_d;
            cnt_q <= cnt_q + 1'b1;
            if (ready_o) begin
                busy_q <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/ex_muldiv.sv
`default_nettype none
// ============================================================================
// Module  : ex_muldiv
// Purpose : Multi-cycle MULT/MULTU/DIV/DIVU unit producing {hi,lo} for HI/LO.
// Revision: 1.0
// ============================================================================
module ex_muldiv
    import ex_muldiv_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int MUL_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              valid_i,
    input  logic [1:0]        op_i,
    input  logic [DATA_W-1:0] opa_i,
    input  logic [DATA_W-1:0] opb_i,
    input  logic              flush_i,
    input  logic              stall_i,
    output logic              stallreq_o,
    output logic              whilo_o,
    output logic [DATA_W-1:0] hi_o,
    output logic [DATA_W-1:0] lo_o
);

    md_state_e               state_q;
    logic                    whilo_q;
    logic [DATA_W-1:0]       hi_q;
    logic [DATA_W-1:0]       lo_q;
    logic [2*DATA_W-1:0]     prod_q;
    logic [MUL_STAGES-1:0]   mul_pipe_q;

    md_op_e                  op;
    logic                    op_signed;
    logic                    accept;
    logic                    div_zero;
    logic                    div_start;
    logic                    div_ready;
    logic [DATA_W-1:0]       div_quo;
    logic [DATA_W-1:0]       div_rem;
    logic [2*DATA_W-1:0]     mul_a_ext;
    logic [2*DATA_W-1:0]     mul_b_ext;
    logic [2*DATA_W-1:0]     product;
    logic                    stallreq;

    assign op        = md_op_e'(op_i);
    assign op_signed = md_is_signed(op);
    assign accept    = (state_q == S_IDLE) & valid_i & ~flush_i;
    assign div_zero  = (opb_i == '0);
    assign div_start = accept & md_is_div(op) & ~div_zero;

    // Sign-extending to the full product width makes one multiplier serve both signednesses.
    assign mul_a_ext = {{DATA_W{op_signed & opa_i[DATA_W-1]}}, opa_i};
    assign mul_b_ext = {{DATA_W{op_signed & opb_i[DATA_W-1]}}, opb_i};
    assign product   = mul_a_ext * mul_b_ext;

    ex_muldiv_div #(
        .DATA_W(DATA_W)
    ) u_div (
        .clk        (clk),
        .rst        (rst),
        .abort_i    (flush_i),
        .start_i    (div_start),
        .signed_i   (op_signed),
        .opa_i      (opa_i),
        .opb_i      (opb_i),
        .ready_o    (div_ready),
        .quotient_o (div_quo),
        .remainder_o(div_rem)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            whilo_q    <= 1'b0;
            hi_q       <= '0;
            lo_q       <= '0;
            prod_q     <= '0;
            mul_pipe_q <= '0;
        end else begin
            mul_pipe_q <= mul_pipe_q << 1;
            if (flush_i) begin
                state_q    <= S_IDLE;
                whilo_q    <= 1'b0;
                hi_q       <= '0;
                lo_q       <= '0;
                mul_pipe_q <= '0;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        if (valid_i) begin
                            if (!md_is_div(op)) begin
                                prod_q     <= product;
                                mul_pipe_q <= MUL_STAGES'(1);
                                state_q    <= S_MUL;
                            end else if (div_zero) begin
                                whilo_q <= 1'b1;
                                hi_q    <= opa_i;
                                lo_q    <= '1;
                                state_q <= S_DONE;
                            end else begin
                                state_q <= S_DIV;
                            end
                        end
                    end
                    S_MUL: begin
                        if (mul_pipe_q[MUL_STAGES-1]) begin
                            whilo_q <= 1'b1;
                            hi_q    <= prod_q[2*DATA_W-1:DATA_W];
                            lo_q    <= prod_q[DATA_W-1:0];
                            state_q <= S_DONE;
                        end
                    end
                    S_DIV: begin
                        if (div_ready) begin
                            whilo_q <= 1'b1;
                            hi_q    <= div_rem;
                            lo_q    <= div_quo;
                            state_q <= S_DONE;
                        end
                    end
                    S_DONE: begin
                        if (!stall_i) begin
                            whilo_q <= 1'b0;
                            hi_q    <= '0;
                            lo_q    <= '0;
                            state_q <= S_IDLE;
                        end
                    end
                    default: state_q <= S_IDLE;
                endcase
            end
        end
    end

    always_comb begin
        stallreq = 1'b0;
        if (!flush_i) begin
            case (state_q)
                S_IDLE:       stallreq = valid_i;
                S_MUL, S_DIV: stallreq = 1'b1;
                default:      stallreq = 1'b0;
            endcase
        end
    end

    // The idle-cycle request is combinational, so gate it so reset silences every output.
    assign stallreq_o = stallreq & ~rst;
    assign whilo_o    = whilo_q & ~flush_i;
    assign hi_o       = hi_q;
    assign lo_o       = lo_q;

endmodule
`default_nettype wire

// File: tb/tb_ex_muldiv.sv
`default_nettype none
// ============================================================================
// Module  : tb_ex_muldiv
// Purpose : Scoreboard bench for ex_muldiv against an arithmetic reference model.
// Revision: 1.0
// ============================================================================
module tb_ex_muldiv;

    localparam int DATA_W     = 32;
    localparam int MUL_STAGES = 2;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          lat;
        int          wcyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        valid_i = 1'b0;
    logic [1:0]  op_i = 2'd0;
    logic [31:0] opa_i = '0;
    logic [31:0] opb_i = '0;
    logic        flush_i = 1'b0;
    logic        stall_i = 1'b0;
    logic        stallreq_o;
    logic        whilo_o;
    logic [31:0] hi_o;
    logic [31:0] lo_o;

    int   n_checks = 0;
    int   n_pass   = 0;
    exp_t exp_q[$];
    int   stall_cnt = 0;
    int   whilo_cnt = 0;

    ex_muldiv #(
        .DATA_W    (DATA_W),
        .MUL_STAGES(MUL_STAGES)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .valid_i   (valid_i),
        .op_i      (op_i),
        .opa_i     (opa_i),
        .opb_i     (opb_i),
        .flush_i   (flush_i),
        .stall_i   (stall_i),
        .stallreq_o(stallreq_o),
        .whilo_o   (whilo_o),
        .hi_o      (hi_o),
        .lo_o      (lo_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: actual=%h required=%h", name, act, req);
    endtask

    // Reference model: plain 64-bit arithmetic on the architectural operands.
    function automatic exp_t model(input logic [1:0] op, input logic [31:0] a,
                                   input logic [31:0] b, input int hold);
        exp_t        e;
        longint      sa, sb;
        logic [63:0] p;
        sa = $signed(a);
        sb = $signed(b);
        e.wcyc = 1 + hold;
        case (op)
            2'd0: begin p = sa * sb; e.hi = p[63:32]; e.lo = p[31:0]; e.lat = 1 + MUL_STAGES; end
            2'd1: begin p = {32'd0, a} * {32'd0, b}; e.hi = p[63:32]; e.lo = p[31:0]; e.lat = 1 + MUL_STAGES; end
            default: begin
                if (b == 32'd0) begin
                    e.hi = a; e.lo = 32'hFFFF_FFFF; e.lat = 1;
                end else if (op == 2'd2) begin
                    p = sa / sb; e.lo = p[31:0];
                    p = sa % sb; e.hi = p[31:0];
                    e.lat = 1 + DATA_W;
                end else begin
                    e.lo = a / b; e.hi = a % b; e.lat = 1 + DATA_W;
                end
            end
        endcase
        return e;
    endfunction

    // Monitor: compares every HI/LO write against the front of the scoreboard.
    always @(negedge clk) begin
        exp_t e;
        if (rst || flush_i) begin
            stall_cnt = 0;
            whilo_cnt = 0;
            if (flush_i) check("flush_no_whilo", {63'd0, whilo_o}, 64'd0);
        end else begin
            if (stallreq_o) stall_cnt++;
            if (whilo_o) begin
                whilo_cnt++;
                check("whilo_expected", 64'(exp_q.size() > 0), 64'd1);
                if (exp_q.size() > 0) begin
                    e = exp_q[0];
                    check("hi", {32'd0, hi_o}, {32'd0, e.hi});
                    check("lo", {32'd0, lo_o}, {32'd0, e.lo});
                    if (whilo_cnt == 1) check("stall_cycles", 64'(stall_cnt), 64'(e.lat));
                    if (!stall_i) begin
                        check("whilo_cycles", 64'(whilo_cnt), 64'(e.wcyc));
                        void'(exp_q.pop_front());
                        stall_cnt = 0;
                        whilo_cnt = 0;
                    end
                end
            end else begin
                check("idle_hi_lo", {hi_o, lo_o}, 64'd0);
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 of the cycle after the op retires.
    task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b, input int hold);
        int cyc;
        int hl;
        bit done;
        exp_q.push_back(model(op, a, b, hold));
        valid_i = 1'b1; op_i = op; opa_i = a; opb_i = b; stall_i = (hold > 0);
        hl = hold; cyc = 0; done = 0;
        while (!done && cyc < 200) begin
            @(negedge clk);
            cyc++;
            if (!stallreq_o) begin
                if (hl > 0) begin
                    hl--;
                    @(posedge clk); #1;
                    if (hl == 0) stall_i = 1'b0;
                end else begin
                    done = 1;
                end
            end else if (cyc >= 2) begin
                op_i = 2'($urandom); opa_i = $urandom; opb_i = $urandom;
            end
        end
        check("issue_done", 64'(done), 64'd1);
        @(posedge clk); #1;
        valid_i = 1'b0; stall_i = 1'b0; opa_i = $urandom; opb_i = $urandom;
    endtask

    function automatic logic [31:0] rand_opnd();
        case ($urandom_range(0, 7))
            0: return 32'd0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return $urandom_range(1, 20);
            default: return $urandom;
        endcase
    endfunction

    initial begin
        #2000000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        #12;
        check("rst_stallreq", {63'd0, stallreq_o}, 64'd0);
        check("rst_whilo", {63'd0, whilo_o}, 64'd0);
        check("rst_hilo", {hi_o, lo_o}, 64'd0);
        @(negedge clk); #1 rst = 1'b0;
        @(posedge clk); #1;

        issue(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
        issue(2'd2, 32'hFFFF_FFF9, 32'd2, 0);
        issue(2'd3, 32'hFFFF_FFF9, 32'd2, 0);
        issue(2'd3, 32'h0000_1234, 32'd0, 0);
        issue(2'd0, 32'hFFFF_FFFD, 32'd5, 3);
        issue(2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 0);
        issue(2'd2, 32'h8000_0005, 32'd0, 1);
        @(posedge clk); #1;

        // Flush on the 10th divide cycle.
        valid_i = 1'b1; op_i = 2'd2; opa_i = 32'd1000; opb_i = 32'd3;
        @(posedge clk); #1;
        repeat (9) begin @(posedge clk); #1; end
        flush_i = 1'b1;
        #1 check("flush_stallreq", {63'd0, stallreq_o}, 64'd0);
        @(posedge clk); #1;
        flush_i = 1'b0; valid_i = 1'b0;
        #1 check("post_flush_stallreq", {63'd0, stallreq_o}, 64'd0);
        repeat (40) @(posedge clk);
        #1;

        // Asynchronous reset in the middle of a divide.
        valid_i = 1'b1; op_i = 2'd2; opa_i = 32'd12345; opb_i = 32'd17;
        repeat (6) @(posedge clk);
        #3 rst = 1'b1; valid_i = 1'b0;
        #1;
        check("arst_stallreq", {63'd0, stallreq_o}, 64'd0);
        check("arst_whilo", {63'd0, whilo_o}, 64'd0);
        check("arst_hilo", {hi_o, lo_o}, 64'd0);
        @(negedge clk); @(negedge clk); #1 rst = 1'b0;
        @(posedge clk); #1;
        issue(2'd2, 32'd100, 32'd7, 0);

        for (int i = 0; i < 40; i++) begin
            logic [1:0] op;
            op = 2'($urandom);
            issue(op, rand_opnd(), rand_opnd(), int'($urandom_range(0, 2)));
            if ($urandom_range(0, 1) == 1) begin @(posedge clk); #1; end
        end

        repeat (5) @(posedge clk);
        #1 check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
